// File: rtl/synth_pkg.sv
// Shared constants for the synth front end: PS/2 set-2 scan codes,
// note codes, octave limits and the prefix-decoder state type.
package synth_pkg;

    localparam logic [7:0] SC_C      = 8'h1C;
    localparam logic [7:0] SC_CS     = 8'h1D;
    localparam logic [7:0] SC_D      = 8'h1B;
    localparam logic [7:0] SC_DS     = 8'h24;
    localparam logic [7:0] SC_E      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_FS     = 8'h2C;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_GS     = 8'h35;
    localparam logic [7:0] SC_A      = 8'h33;
    localparam logic [7:0] SC_AS     = 8'h3C;
    localparam logic [7:0] SC_B      = 8'h3B;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;
    localparam logic [7:0] SC_VOL_DN = 8'h4E;
    localparam logic [7:0] SC_VOL_UP = 8'h55;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    localparam logic [2:0] OCT_MIN = 3'd0;
    localparam logic [2:0] OCT_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

endpackage

// File: rtl/scancode_to_note.sv
// Combinational map from a set-2 make code to a piano-row note code.
import synth_pkg::*;

module scancode_to_note (
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic [3:0] o_note
);

    always_comb begin
        o_hit  = 1'b1;
        o_note = NOTE_C;
        case (i_code)
            SC_C:    o_note = NOTE_C;
            SC_CS:   o_note = NOTE_CS;
            SC_D:    o_note = NOTE_D;
            SC_DS:   o_note = NOTE_DS;
            SC_E:    o_note = NOTE_E;
            SC_F:    o_note = NOTE_F;
            SC_FS:   o_note = NOTE_FS;
            SC_G:    o_note = NOTE_G;
            SC_GS:   o_note = NOTE_GS;
            SC_A:    o_note = NOTE_A;
            SC_AS:   o_note = NOTE_AS;
            SC_B:    o_note = NOTE_B;
            default: o_hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 scan bytes -> note/octave/amplitude command stream.
// Volume keys 4E/55 are active only when PS2_NOTE_AMP_KEYS_EN is defined.
import synth_pkg::*;

module ps2_note_decoder #(
    parameter int DEFAULT_OCTAVE = 4,
    parameter int DEFAULT_AMP    = 32,
    parameter int AMP_STEP       = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_scan_valid,
    input  logic [7:0] i_scan_code,
    output logic       o_note_in,
    output logic [3:0] o_note,
    output logic [2:0] o_octave,
    output logic [5:0] o_amplitude,
    output logic       o_key_held,
    output logic       o_note_off
);

    ps2_state_t r_state;
    logic [2:0] r_oct_sel;
    logic [7:0] r_held_code;
    logic       r_note_in;
    logic       r_note_off;
    logic [3:0] r_note;
    logic [2:0] r_octave;
    logic [5:0] r_amplitude;
    logic       r_key_held;

    logic       w_hit;
    logic [3:0] w_note;
    logic       w_repeat;
    logic       w_vol_up;
    logic       w_vol_dn;
    logic [6:0] w_amp_add;
    logic [6:0] w_amp_sub;

    scancode_to_note u_map (
        .i_code (i_scan_code),
        .o_hit  (w_hit),
        .o_note (w_note)
    );

    assign w_repeat = r_key_held && (i_scan_code == r_held_code);

`ifdef PS2_NOTE_AMP_KEYS_EN
    assign w_vol_up = (i_scan_code == SC_VOL_UP);
    assign w_vol_dn = (i_scan_code == SC_VOL_DN);
`else
    assign w_vol_up = 1'b0;
    assign w_vol_dn = 1'b0;
`endif

    // 7-bit sums: bit 6 flags overflow on add and borrow on subtract
    assign w_amp_add = {1'b0, r_amplitude} + 7'(AMP_STEP);
    assign w_amp_sub = {1'b0, r_amplitude} - 7'(AMP_STEP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_oct_sel   <= 3'(DEFAULT_OCTAVE);
            r_held_code <= 8'h00;
            r_note_in   <= 1'b0;
            r_note_off  <= 1'b0;
            r_note      <= NOTE_C;
            r_octave    <= 3'(DEFAULT_OCTAVE);
            r_amplitude <= 6'(DEFAULT_AMP);
            r_key_held  <= 1'b0;
        end else begin
            r_note_in  <= 1'b0;
            r_note_off <= 1'b0;
            if (i_scan_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_scan_code == SC_BRK) begin
                            r_state <= ST_BRK;
                        end else if (i_scan_code == SC_EXT) begin
                            r_state <= ST_EXT;
                        end else if (w_hit) begin
                            if (!w_repeat) begin
                                r_note      <= w_note;
                                r_octave    <= r_oct_sel;
                                r_held_code <= i_scan_code;
                                r_key_held  <= 1'b1;
                                r_note_in   <= 1'b1;
                            end
                        end else if (i_scan_code == SC_OCT_DN) begin
                            if (r_oct_sel != OCT_MIN) r_oct_sel <= r_oct_sel - 3'd1;
                        end else if (i_scan_code == SC_OCT_UP) begin
                            if (r_oct_sel != OCT_MAX) r_oct_sel <= r_oct_sel + 3'd1;
                        end else if (w_vol_up) begin
                            r_amplitude <= (w_amp_add > 7'd63) ? 6'd63 : w_amp_add[5:0];
                        end else if (w_vol_dn) begin
                            r_amplitude <= w_amp_sub[6] ? 6'd0 : w_amp_sub[5:0];
                        end
                    end
                    ST_BRK: begin
                        if (i_scan_code != SC_BRK) begin
                            if (w_repeat) begin
                                r_key_held <= 1'b0;
                                r_note_off <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_EXT: begin
                        r_state <= (i_scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_note_in   = r_note_in;
    assign o_note_off  = r_note_off;
    assign o_note      = r_note;
    assign o_octave    = r_octave;
    assign o_amplitude = r_amplitude;
    assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Scoreboard bench for ps2_note_decoder; volume-key cases build only
// with PS2_NOTE_AMP_KEYS_EN defined.
module tb_ps2_note_decoder;

    typedef struct {
        logic       is_on;
        logic [3:0] note;
        logic [2:0] oct;
        logic       held;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       note_in;
    logic [3:0] note;
    logic [2:0] octave;
    logic [5:0] amplitude;
    logic       key_held;
    logic       note_off;

    int n_checks = 0;
    int n_errors = 0;
    ev_t exp_q[$];
    bit  done = 1'b0;

    ps2_note_decoder #(.DEFAULT_OCTAVE(4), .DEFAULT_AMP(32), .AMP_STEP(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_scan_valid (scan_valid),
        .i_scan_code  (scan_code),
        .o_note_in    (note_in),
        .o_note       (note),
        .o_octave     (octave),
        .o_amplitude  (amplitude),
        .o_key_held   (key_held),
        .o_note_off   (note_off)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic on, input logic [3:0] n, input logic [2:0] o);
        ev_t e;
        e.is_on = on;
        e.note  = n;
        e.oct   = o;
        e.held  = on;
        exp_q.push_back(e);
    endtask

    // One byte, then an idle gap; outputs of the byte are visible on return.
    task automatic send(input logic [7:0] code);
        @(posedge clk); #1;
        scan_valid = 1'b1;
        scan_code  = code;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_n(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) send(code);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!done && (note_in || note_off)) begin
            chk("pulse_exclusive", int'(note_in && note_off), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got note_in=%0d note_off=%0d note=%0d expected none",
                         note_in, note_off, note);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_note_in", int'(note_in), int'(e.is_on));
                chk("ev_note",    int'(note),    int'(e.note));
                chk("ev_octave",  int'(octave),  int'(e.oct));
                chk("ev_held",    int'(key_held), int'(e.held));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_note_in",  int'(note_in),   0);
        chk("rst_note_off", int'(note_off),  0);
        chk("rst_note",     int'(note),      0);
        chk("rst_octave",   int'(octave),    4);
        chk("rst_amp",      int'(amplitude), 32);
        chk("rst_held",     int'(key_held),  0);

        // Single press, then typematic repeats, then release
        push(1'b1, 4'd0, 3'd4);
        send(8'h1C);
        chk("press_held", int'(key_held), 1);
        send_n(8'h1C, 2);
        push(1'b0, 4'd0, 3'd4);
        send(8'hF0);
        send(8'h1C);
        chk("release_held", int'(key_held), 0);

        // Octave selection saturates high, does not move latched octave
        send_n(8'h22, 5);
        chk("oct_sel_no_move", int'(octave), 4);
        push(1'b1, 4'd9, 3'd6);
        send(8'h33);
        push(1'b0, 4'd9, 3'd6);
        send(8'hF0);
        send(8'h33);
        send_n(8'h1A, 9);
        push(1'b1, 4'd2, 3'd0);
        send(8'h1B);
        push(1'b0, 4'd2, 3'd0);
        send(8'hF0);
        send(8'h1B);

        // Retrigger; release of the older key is ignored
        push(1'b1, 4'd0, 3'd0);
        send(8'h1C);
        push(1'b1, 4'd11, 3'd0);
        send(8'h3B);
        send(8'hF0);
        send(8'h1C);
        chk("retrig_held", int'(key_held), 1);
        chk("retrig_note", int'(note), 11);
        push(1'b0, 4'd11, 3'd0);
        send(8'hF0);
        send(8'h3B);

        // Extended prefixes discard the following byte(s)
        send(8'hE0);
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        chk("ext_held", int'(key_held), 0);
        push(1'b1, 4'd0, 3'd0);
        send(8'h1C);
        push(1'b0, 4'd0, 3'd0);
        send(8'hF0);
        send(8'h1C);

        // Back-to-back bytes: press then release in consecutive cycles
        push(1'b1, 4'd7, 3'd0);
        push(1'b0, 4'd7, 3'd0);
        @(posedge clk); #1;
        scan_valid = 1'b1; scan_code = 8'h34;
        @(posedge clk); #1;
        scan_code = 8'hF0;
        @(posedge clk); #1;
        scan_code = 8'h34;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("b2b_held", int'(key_held), 0);

`ifdef PS2_NOTE_AMP_KEYS_EN
        send_n(8'h55, 9);
        chk("amp_sat_hi", int'(amplitude), 63);
        send_n(8'h4E, 20);
        chk("amp_sat_lo", int'(amplitude), 0);
        send(8'h55);
        chk("amp_step", int'(amplitude), 4);
`else
        send(8'h55);
        send(8'h4E);
        send(8'h55);
        chk("amp_const", int'(amplitude), 32);
`endif

        // Reset after F0 drops the prefix; octave back to default
        send(8'hF0);
        do_reset();
        chk("rst2_octave", int'(octave), 4);
        chk("rst2_amp",    int'(amplitude), 32);
        push(1'b1, 4'd0, 3'd4);
        send(8'h1C);

        // Reset wins over a simultaneous byte
        @(posedge clk); #1;
        reset = 1'b1; scan_valid = 1'b1; scan_code = 8'h3B;
        @(posedge clk); #1;
        reset = 1'b0; scan_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid_held", int'(key_held), 0);
        chk("rst_valid_note", int'(note), 0);

        repeat (5) @(posedge clk);
        #1 done = 1'b1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
